// File: rtl/vga_rect_plotter.sv
// Rectangle plotter for vga_adapter. It draws a fill, an outline or a
// full-screen clear at one pixel per clock in row-major order, clipped to the screen.
module vga_rect_plotter #(
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120,
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int SIZE_WIDTH   = 8,
  parameter int COLOUR_WIDTH = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [X_WIDTH-1:0]      x0,
  input  logic [Y_WIDTH-1:0]      y0,
  input  logic [SIZE_WIDTH-1:0]   w,
  input  logic [SIZE_WIDTH-1:0]   h,
  input  logic [COLOUR_WIDTH-1:0] colour_in,
  output logic [X_WIDTH-1:0]      x,
  output logic [Y_WIDTH-1:0]      y,
  output logic [COLOUR_WIDTH-1:0] colour,
  output logic                    plot,
  output logic                    busy,
  output logic                    done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Internal coordinates are wide enough that x0+w-1 never wraps.
  localparam int XW = X_WIDTH + SIZE_WIDTH + 1;
  localparam int YW = Y_WIDTH + SIZE_WIDTH + 1;

  localparam logic [XW-1:0] X_MAX = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_H - 1);
  localparam logic [XW-1:0] X_LIM = XW'(SCREEN_W);
  localparam logic [YW-1:0] Y_LIM = YW'(SCREEN_H);

  logic [1:0]              state_reg;
  logic                    outline_reg;
  logic [XW-1:0]           x0_reg, xe_reg, xr_reg, cx_reg;
  logic [YW-1:0]           y0_reg, ye_reg, yb_reg, cy_reg;
  logic [COLOUR_WIDTH-1:0] colour_reg;
  logic [X_WIDTH-1:0]      x_reg;
  logic [Y_WIDTH-1:0]      y_reg;
  logic [COLOUR_WIDTH-1:0] colour_out_reg;
  logic                    plot_reg;
  logic                    done_reg;

  // Command-side rectangle (clear overrides the geometry).
  logic [XW-1:0] ax0, aw, ax_end, axe;
  logic [YW-1:0] ay0, ah, ay_end, aye;
  logic          a_empty;

  always_comb begin
    if (cmd_op == 2'b10) begin
      ax0 = '0;
      ay0 = '0;
      aw  = X_LIM;
      ah  = Y_LIM;
    end else begin
      ax0 = XW'(x0);
      ay0 = YW'(y0);
      aw  = XW'(w);
      ah  = YW'(h);
    end
    ax_end  = ax0 + aw - XW'(1);
    ay_end  = ay0 + ah - YW'(1);
    axe     = (ax_end > X_MAX) ? X_MAX : ax_end;
    aye     = (ay_end > Y_MAX) ? Y_MAX : ay_end;
    a_empty = (aw == '0) || (ah == '0) || (ax0 >= X_LIM) || (ay0 >= Y_LIM);
  end

  // Next scan position and whether it lies on the unclipped outline.
  logic          last_px;
  logic [XW-1:0] nx_next;
  logic [YW-1:0] ny_next;
  logic          nplot_next;

  always_comb begin
    last_px = (cx_reg == xe_reg) && (cy_reg == ye_reg);
    if (cx_reg == xe_reg) begin
      nx_next = x0_reg;
      ny_next = cy_reg + YW'(1);
    end else begin
      nx_next = cx_reg + XW'(1);
      ny_next = cy_reg;
    end
    nplot_next = !outline_reg || (nx_next == x0_reg) || (ny_next == y0_reg) ||
                 (nx_next == xr_reg) || (ny_next == yb_reg);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      outline_reg    <= 1'b0;
      x0_reg         <= '0;
      y0_reg         <= '0;
      xe_reg         <= '0;
      ye_reg         <= '0;
      xr_reg         <= '0;
      yb_reg         <= '0;
      cx_reg         <= '0;
      cy_reg         <= '0;
      colour_reg     <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      colour_out_reg <= '0;
      plot_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      plot_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (cmd_valid) begin
            outline_reg <= (cmd_op == 2'b01);
            x0_reg      <= ax0;
            y0_reg      <= ay0;
            xe_reg      <= axe;
            ye_reg      <= aye;
            xr_reg      <= ax_end;
            yb_reg      <= ay_end;
            cx_reg      <= ax0;
            cy_reg      <= ay0;
            colour_reg  <= colour_in;
            if (a_empty) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              // Top-left corner is on every outline, so it always plots.
              state_reg      <= ST_SCAN;
              plot_reg       <= 1'b1;
              x_reg          <= ax0[X_WIDTH-1:0];
              y_reg          <= ay0[Y_WIDTH-1:0];
              colour_out_reg <= colour_in;
            end
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (last_px) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else begin
            cx_reg <= nx_next;
            cy_reg <= ny_next;
            if (nplot_next) begin
              plot_reg       <= 1'b1;
              x_reg          <= nx_next[X_WIDTH-1:0];
              y_reg          <= ny_next[Y_WIDTH-1:0];
              colour_out_reg <= colour_reg;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_reg == ST_SCAN);
  assign cmd_ready = ~busy;
  assign x         = x_reg;
  assign y         = y_reg;
  assign colour    = colour_out_reg;
  assign plot      = plot_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_vga_rect_plotter.sv
// Scoreboard bench for vga_rect_plotter: commands push expected pixels and done
// pulses (with their cycle numbers) into queues; a monitor pops and compares.
module tb_vga_rect_plotter;

  localparam int W = 160;
  localparam int H = 120;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [7:0] x0 = '0;
  logic [6:0] y0 = '0;
  logic [7:0] w = '0;
  logic [7:0] h = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  vga_rect_plotter dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .x0(x0), .y0(y0), .w(w), .h(h), .colour_in(colour_in),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int x;
    int y;
    int col;
  } pix_t;

  pix_t pq[$];
  int   dq[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   last_a = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: enumerate the clipped rectangle row by row; the outline test uses
  // the unclipped edges.
  task automatic model(input int a, input int op, input int xs, input int ys,
                       input int ws, input int hs, input int col, output int n);
    int xe, ye, k;
    if (op == 2) begin
      xs = 0; ys = 0; ws = W; hs = H;
    end
    n = 0;
    if (ws == 0 || hs == 0 || xs >= W || ys >= H) begin
      dq.push_back(a + 1);
      return;
    end
    xe = (xs + ws - 1 < W - 1) ? xs + ws - 1 : W - 1;
    ye = (ys + hs - 1 < H - 1) ? ys + hs - 1 : H - 1;
    k = 0;
    for (int yy = ys; yy <= ye; yy++) begin
      for (int xx = xs; xx <= xe; xx++) begin
        if (op != 1 || xx == xs || yy == ys || xx == xs + ws - 1 || yy == ys + hs - 1)
          pq.push_back('{a + 1 + k, xx, yy, col});
        k++;
      end
    end
    n = k;
    dq.push_back(a + 1 + k);
  endtask

  // Called and returns on a falling edge.
  task automatic issue(input int op, input int xa, input int ya, input int wa,
                       input int ha, input int col, input bit poke);
    int t, n;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 30000) begin
      @(negedge clock);
      t++;
    end
    chk("ready_wait", int'(cmd_ready === 1'b1), 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    x0        = 8'(xa);
    y0        = 7'(ya);
    w         = 8'(wa);
    h         = 8'(ha);
    colour_in = 3'(col);
    last_a    = cyc;
    model(cyc, op, xa, ya, wa, ha, col, n);
    $display("cmd op=%0d x0=%0d y0=%0d w=%0d h=%0d col=%0d accepted at cycle %0d, %0d scan cycles",
             op, xa, ya, wa, ha, col, last_a, n);
    @(negedge clock);
    cmd_valid = 1'b0;
    if (n > 0) begin
      chk("busy_after_accept", int'(busy), 1);
      if (poke) begin
        // Garbage command while busy must be ignored.
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 3));
        x0        = 8'($urandom_range(0, 20));
        y0        = 7'($urandom_range(0, 20));
        w         = 8'($urandom_range(1, 9));
        h         = 8'($urandom_range(1, 9));
        @(negedge clock);
        cmd_valid = 1'b0;
      end
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    if (plot === 1'b1) begin
      if (pq.size() == 0) begin
        chk("spurious_plot", int'(plot), 0);
      end else begin
        pix_t p;
        p = pq.pop_front();
        chk("pix_cycle", cyc, p.cyc);
        chk("pix_x", int'(x), p.x);
        chk("pix_y", int'(y), p.y);
        chk("pix_colour", int'(colour), p.col);
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) chk("spurious_done", int'(done), 0);
      else chk("done_cycle", cyc, dq.pop_front());
    end
  end

  initial begin
    int t;
    repeat (3) @(negedge clock);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", int'(cmd_ready), 1);

    issue(0, 10, 20, 4, 4, 5, 1'b0);
    issue(0, 158, 118, 4, 4, 3, 1'b0);
    issue(1, 0, 0, 4, 3, 6, 1'b0);
    issue(1, 157, 0, 5, 2, 2, 1'b0);
    issue(0, 150, 100, 255, 255, 7, 1'b0);
    issue(2, 33, 44, 1, 1, 0, 1'b0);
    issue(0, 5, 5, 3, 2, 4, 1'b0);
    issue(0, 5, 5, 0, 3, 1, 1'b0);
    issue(0, 160, 5, 3, 3, 1, 1'b0);
    issue(3, 1, 1, 2, 2, 6, 1'b0);
    issue(1, 20, 20, 1, 5, 2, 1'b0);
    issue(1, 30, 40, 6, 5, 3, 1'b1);
    issue(0, 0, 119, 255, 1, 1, 1'b1);

    // Reset five cycles into a 4x4 fill.
    issue(0, 10, 20, 4, 4, 5, 1'b0);
    while (cyc < last_a + 5) @(negedge clock);
    reset = 1'b1;
    begin
      pix_t keep_p[$];
      int   keep_d[$];
      foreach (pq[i]) if (pq[i].cyc <= last_a + 5) keep_p.push_back(pq[i]);
      foreach (dq[i]) if (dq[i] <= last_a + 5) keep_d.push_back(dq[i]);
      pq = keep_p;
      dq = keep_d;
    end
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_plot", int'(plot), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    $display("reset applied at cycle %0d", last_a + 5);
    @(negedge clock);
    issue(0, 10, 20, 4, 4, 2, 1'b1);

    for (int i = 0; i < 40; i++) begin
      issue($urandom_range(0, 3), $urandom_range(0, 170), $urandom_range(0, 127),
            $urandom_range(0, 24), $urandom_range(0, 24), $urandom_range(0, 7),
            1'($urandom_range(0, 1)));
    end

    t = 0;
    while ((pq.size() != 0 || dq.size() != 0) && t < 30000) begin
      @(negedge clock);
      t++;
    end
    repeat (3) @(negedge clock);
    chk("pixels_left", pq.size(), 0);
    chk("dones_left", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
